// File: rtl/rv32i_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue and IMEM.
interface rv32i_fetch_queue_if;
    logic [31:0] iaddr;     // address of the current request
    logic        stb_inst;  // request strobe, accepted every strobed cycle
    logic        ack_inst;  // in-order response valid
    logic [31:0] inst;      // response data

    modport master (output iaddr, output stb_inst, input ack_inst, input inst);
    modport slave  (input iaddr, input stb_inst, output ack_inst, output inst);
endinterface

// File: rtl/rv32i_fetch_queue.sv
// Prefetching fetch stage: pipelined IMEM reads, PC-tagged FIFO, redirect flush
// with stale-response discard, registered output to the decoder.
`ifndef STALL_WIDTH
`define STALL_WIDTH 5
`endif
`ifndef FETCH
`define FETCH 0
`endif
`ifndef DECODER
`define DECODER 1
`endif
`ifndef ALU
`define ALU 2
`endif
`ifndef MEMORYACCESS
`define MEMORYACCESS 3
`endif
`ifndef WRITEBACK
`define WRITEBACK 4
`endif

module rv32i_fetch_queue #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    rv32i_fetch_queue_if.master     io_imem,
    input  logic                    i_writeback_change_pc,
    input  logic [31:0]             i_writeback_next_pc,
    input  logic                    i_alu_change_pc,
    input  logic [31:0]             i_alu_next_pc,
    input  logic                    i_ce,
    input  logic [`STALL_WIDTH-1:0] i_stall,
    input  logic                    i_flush,
    output logic [31:0]             o_pc,
    output logic [31:0]             o_inst,
    output logic                    o_ce,
    output logic                    o_stall
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [CW:0]     OCC_MAX = (CW+1)'(DEPTH);

    logic [31:0]   r_iaddr;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_inflight;   // every outstanding request, stale ones included
    logic [CW-1:0] r_discard;    // how many of r_inflight belong to a dead stream
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_inst [DEPTH];

    logic          w_redirect;
    logic [31:0]   w_target;
    logic          w_hold;
    logic [CW:0]   w_occ;
    logic          w_stb;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_redir_discard;

    assign w_redirect = i_writeback_change_pc | i_alu_change_pc;
    assign w_target   = i_writeback_change_pc ? i_writeback_next_pc : i_alu_next_pc;
    assign w_hold     = i_stall[`DECODER] | i_stall[`ALU] |
                        i_stall[`MEMORYACCESS] | i_stall[`WRITEBACK];
    assign w_ack      = io_imem.ack_inst;

    // A slot is reserved per outstanding request, so the FIFO can never overflow.
    assign w_occ      = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_stb      = i_ce & ~w_redirect & (w_occ < OCC_MAX);
    assign w_push     = w_ack & ~w_redirect & (r_discard == '0);
    assign w_pop      = ~w_hold & ~w_redirect & ~i_flush & ~i_stall[`FETCH] & (r_count != '0);

    // On redirect everything still outstanding (minus this cycle's ack) is stale;
    // earlier stale requests are already part of r_inflight, so no double count.
    assign w_redir_discard = w_ack ? ((r_inflight == '0) ? '0 : r_inflight - ONE) : r_inflight;

    assign io_imem.iaddr    = r_iaddr;
    assign io_imem.stb_inst = w_stb;
    assign o_stall          = i_ce & (r_count == '0);

    // Request address, response tagging, in-flight/discard accounting and FIFO pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iaddr    <= PC_RESET;
            r_resp_pc  <= PC_RESET;
            r_inflight <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            case ({w_stb, w_ack})
                2'b10:   r_inflight <= r_inflight + ONE;
                2'b01:   r_inflight <= (r_inflight == '0) ? '0 : r_inflight - ONE;
                default: ;
            endcase

            if (w_redirect) begin
                r_iaddr   <= w_target;
                r_resp_pc <= w_target;
                r_discard <= w_redir_discard;
                r_count   <= '0;
                r_wptr    <= '0;
                r_rptr    <= '0;
            end else begin
                if (w_stb)
                    r_iaddr <= r_iaddr + 32'd4;
                if (w_ack && r_discard != '0)
                    r_discard <= r_discard - ONE;
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wptr    <= r_wptr + AW'(1);
                end
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + ONE;
                    2'b01:   r_count <= r_count - ONE;
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage: PC and instruction word written together on push.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_resp_pc;
            r_fifo_inst[r_wptr] <= io_imem.inst;
        end
    end

    // Decoder-facing register: frozen under hold, otherwise loads the FIFO head.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pc   <= '0;
            o_inst <= '0;
            o_ce   <= 1'b0;
        end else if (!w_hold) begin
            if (w_redirect || i_flush || i_stall[`FETCH]) begin
                o_ce <= 1'b0;
            end else if (r_count != '0) begin
                o_pc   <= r_fifo_pc[r_rptr];
                o_inst <= r_fifo_inst[r_rptr];
                o_ce   <= 1'b1;
            end else begin
                o_ce <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Bench for rv32i_fetch_queue: IMEM model with configurable latency and an
// instruction-stream reference (expected PC sequence restarted at each redirect).
`ifndef STALL_WIDTH
`define STALL_WIDTH 5
`endif
`ifndef FETCH
`define FETCH 0
`endif
`ifndef DECODER
`define DECODER 1
`endif
`ifndef ALU
`define ALU 2
`endif
`ifndef MEMORYACCESS
`define MEMORYACCESS 3
`endif
`ifndef WRITEBACK
`define WRITEBACK 4
`endif

module tb_rv32i_fetch_queue;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    wb_chg, alu_chg, ce, flush;
    logic [31:0]             wb_pc, alu_pc;
    logic [`STALL_WIDTH-1:0] stall;
    logic [31:0]             o_pc, o_inst;
    logic                    o_ce, o_stall;

    rv32i_fetch_queue_if bus();

    rv32i_fetch_queue #(.PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .io_imem(bus),
        .i_writeback_change_pc(wb_chg), .i_writeback_next_pc(wb_pc),
        .i_alu_change_pc(alu_chg), .i_alu_next_pc(alu_pc),
        .i_ce(ce), .i_stall(stall), .i_flush(flush),
        .o_pc(o_pc), .o_inst(o_inst), .o_ce(o_ce), .o_stall(o_stall)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t q[$];

    int ntests = 0, nfail = 0;
    int cyc, lat, last_due, consumed, strobes, acks_seen, first_ce_cyc;
    logic [31:0] exp_pc, exp_iaddr, last_cons_pc;
    logic        prev_hold, prev_ce;
    logic [31:0] prev_pc, prev_inst;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wb_chg = 1'b0; alu_chg = 1'b0; flush = 1'b0; stall = '0;
        wb_pc = '0; alu_pc = '0; bus.ack_inst = 1'b0; bus.inst = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        cyc = 0; last_due = -1; consumed = 0; strobes = 0; acks_seen = 0; first_ce_cyc = -1;
        exp_pc = PC_RESET; exp_iaddr = PC_RESET; prev_hold = 1'b0;
    endtask

    // One clock cycle: IMEM response, sample and check outputs, advance the model.
    task automatic tick();
        logic        hold, redirect;
        logic [31:0] tgt;
        int          due;
        if (q.size() > 0 && q[0].due <= cyc) begin
            bus.ack_inst = 1'b1;
            bus.inst     = mem(q[0].addr);
            void'(q.pop_front());
            acks_seen++;
        end else begin
            bus.ack_inst = 1'b0;
            bus.inst     = $urandom;
        end
        #1;
        hold     = stall[`DECODER] | stall[`ALU] | stall[`MEMORYACCESS] | stall[`WRITEBACK];
        redirect = wb_chg | alu_chg;
        tgt      = wb_chg ? wb_pc : alu_pc;
        if (prev_hold) begin
            chk("hold_ce", o_ce, prev_ce);
            chk("hold_pc", o_pc, prev_pc);
            chk("hold_inst", o_inst, prev_inst);
        end
        if (o_ce && !hold) begin
            chk("stream_pc", o_pc, exp_pc);
            chk("stream_inst", o_inst, mem(exp_pc));
            last_cons_pc = o_pc;
            exp_pc += 32'd4;
            consumed++;
            if (first_ce_cyc < 0) first_ce_cyc = cyc;
        end
        if (redirect) chk("no_stb_on_redirect", bus.stb_inst, 1'b0);
        if (bus.stb_inst) begin
            chk("iaddr", bus.iaddr, exp_iaddr);
            exp_iaddr += 32'd4;
            strobes++;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q.push_back('{addr: bus.iaddr, due: due});
            chk("outstanding_le_depth", 32'(q.size() <= DEPTH), 32'd1);
        end
        if (redirect) begin
            exp_pc    = tgt;
            exp_iaddr = tgt;
        end
        prev_hold = hold; prev_ce = o_ce; prev_pc = o_pc; prev_inst = o_inst;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int c0, s0, n;
        logic [2:0] r;

        // Reset state and back-to-back streaming at latency 1
        ce = 1'b1; lat = 1;
        do_reset();
        chk("rst_iaddr", bus.iaddr, PC_RESET);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_ce", o_ce, 1'b0);
        chk("rst_stall_empty", o_stall, 1'b1);
        repeat (12) tick();
        chk("t1_first_ce_cycle", 32'(first_ce_cyc), 32'd3);
        chk("t1_consumed", 32'(consumed), 32'd9);

        // Long latency: only DEPTH requests before the first response
        lat = 6;
        do_reset();
        n = 0;
        while (acks_seen == 0 && n < 40) begin tick(); n++; end
        chk("t2_ack_seen", 32'(acks_seen > 0), 32'd1);
        chk("t2_strobes_before_ack", 32'(strobes), 32'(DEPTH));
        repeat (20) tick();

        // ALU redirect with three requests in flight
        lat = 6;
        do_reset();
        repeat (3) tick();
        alu_chg = 1'b1; alu_pc = 32'h100;
        tick();
        alu_chg = 1'b0;
        c0 = consumed; n = 0;
        while (consumed == c0 && n < 40) begin tick(); n++; end
        chk("t3_first_pc", last_cons_pc, 32'h100);
        repeat (10) tick();

        // Simultaneous redirects: writeback wins
        lat = 2;
        do_reset();
        repeat (10) tick();
        wb_chg = 1'b1; wb_pc = 32'h80; alu_chg = 1'b1; alu_pc = 32'h200;
        tick();
        wb_chg = 1'b0; alu_chg = 1'b0;
        c0 = consumed; n = 0;
        while (consumed == c0 && n < 40) begin tick(); n++; end
        chk("t4_first_pc", last_cons_pc, 32'h80);

        // ALU stall with a full FIFO: frozen output, no strobes
        lat = 1;
        do_reset();
        repeat (6) tick();
        stall[`ALU] = 1'b1;
        repeat (5) tick();
        s0 = strobes;
        repeat (5) tick();
        chk("t5_no_strobes_full", 32'(strobes - s0), 32'd0);
        chk("t5_ce_held", o_ce, 1'b1);
        stall = '0;
        c0 = consumed;
        repeat (10) tick();
        chk("t5_resumed", 32'(consumed - c0), 32'd10);

        // Flush with no hold
        lat = 1;
        do_reset();
        repeat (8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_ce", o_ce, 1'b0);
        c0 = consumed;
        repeat (8) tick();
        chk("t6_continues", 32'(consumed > c0), 32'd1);

        // Fetch disabled: no requests, not reported as starved
        ce = 1'b0;
        do_reset();
        repeat (5) tick();
        chk("t7_no_strobes", 32'(strobes), 32'd0);
        chk("t7_no_starve", o_stall, 1'b0);

        // Randomized traffic
        ce = 1'b1; lat = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 5);
            ce    = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 6) == 0) ? `STALL_WIDTH'($urandom) : '0;
            flush = ($urandom_range(0, 19) == 0);
            wb_chg = 1'b0; alu_chg = 1'b0;
            if (!(stall[`DECODER] | stall[`ALU] | stall[`MEMORYACCESS] | stall[`WRITEBACK])
                && $urandom_range(0, 24) == 0) begin
                r = 3'($urandom);
                wb_chg  = r[0] | ~r[1];
                alu_chg = r[1];
                wb_pc   = r[2] ? (32'hFFFF_FFF0 | {28'h0, 2'($urandom), 2'b00}) : {$urandom} & ~32'h3;
                alu_pc  = {$urandom} & ~32'h3;
            end
            tick();
        end
        ce = 1'b1; stall = '0; flush = 1'b0; wb_chg = 1'b0; alu_chg = 1'b0;
        c0 = consumed;
        repeat (40) tick();
        chk("rand_drain_progress", 32'(consumed > c0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
